// File: rtl/systolic_result_drain.sv
// Snapshots the ROWS x COLS accumulator array on start and streams it one element per beat.
// Latency: first beat valid the cycle after the start edge; holds all outputs while out_ready is low.
module systolic_result_drain #(
    parameter int ROWS       = 3,
    parameter int COLS       = 3,
    parameter int DATA_WIDTH = 16,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ROWS*COLS*DATA_WIDTH-1:0] in_results,
    input  logic                            start,
    input  logic                            col_major,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [RW-1:0]                   out_row,
    output logic [CW-1:0]                   out_col,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state;
    logic [ROWS*COLS*DATA_WIDTH-1:0] r_snap;
    logic                            r_col_major;
    logic [RW-1:0]                   r_row;
    logic [CW-1:0]                   r_col;
    logic [RW-1:0]                   w_row_nxt;
    logic [CW-1:0]                   w_col_nxt;
    logic                            w_last;
    logic                            w_hs;
    logic [DATA_WIDTH-1:0]           w_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Status outputs decode straight from the state so reset drops them without a clock edge.
    always_comb begin
        w_state   = r_state;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_STREAM;
                end
            end
            S_STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && w_last) begin
                    w_state = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign w_last = (r_state == S_STREAM) && (r_row == ROW_MAX) && (r_col == COL_MAX);
    assign w_hs   = (r_state == S_STREAM) && out_ready;

    // Scan advance: the fast index wraps and carries into the slow one, which wraps after the last beat.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (r_col_major) begin
            if (r_row == ROW_MAX) begin
                w_row_nxt = '0;
                w_col_nxt = (r_col == COL_MAX) ? '0 : r_col + 1'b1;
            end else begin
                w_row_nxt = r_row + 1'b1;
            end
        end else begin
            if (r_col == COL_MAX) begin
                w_col_nxt = '0;
                w_row_nxt = (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
            end else begin
                w_col_nxt = r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap      <= '0;
            r_col_major <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_snap      <= in_results;
            r_col_major <= col_major;
            r_row       <= '0;
            r_col       <= '0;
        end else if (w_hs) begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                if ((r_row == RW'(i)) && (r_col == CW'(j))) begin
                    w_data = r_snap[(i*COLS+j)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign out_data = w_data;
    assign out_row  = r_row;
    assign out_col  = r_col;
    assign out_last = w_last;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed sequence of tiles with random data/ready, checked against a queue-based scan-order model.
module tb_systolic_result_drain;

    localparam int R  = 3;
    localparam int C  = 3;
    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic [R*C*DW-1:0] in_results;
    logic              start;
    logic              col_major;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_row;
    logic [1:0]        out_col;
    logic              out_last;
    logic              busy;
    logic              done;

    systolic_result_drain #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_results(in_results), .start(start),
        .col_major(col_major), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy), .done(done)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            row;
        int            col;
        bit            last;
    } beat_t;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] m [R][C];
    beat_t         exp_q [$];
    bit            pat [6] = '{1, 0, 0, 1, 0, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                m[i][j] = DW'(10 * i + j);
    endtask

    task automatic fill_random();
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                m[i][j] = DW'($urandom);
    endtask

    task automatic scramble_inputs();
        for (int k = 0; k < R * C; k++)
            in_results[k*DW +: DW] = DW'($urandom);
    endtask

    // Expected beats: element order depends only on scan mode; last is the final element of the tile.
    task automatic build_exp(input bit cm);
        beat_t b;
        exp_q.delete();
        for (int a = 0; a < (cm ? C : R); a++) begin
            for (int k = 0; k < (cm ? R : C); k++) begin
                b.row  = cm ? k : a;
                b.col  = cm ? a : k;
                b.data = m[b.row][b.col];
                b.last = (exp_q.size() == R * C - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge of the first STREAM cycle.
    task automatic start_tile(input bit cm);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                in_results[(i*C+j)*DW +: DW] = m[i][j];
        col_major = cm;
        start     = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        col_major  = ~cm;
        in_results = '1;
        build_exp(cm);
    endtask

    // rmode: 0 ready high, 1 fixed 1,0,0,1,0,1 pattern, 2 random.
    task automatic drain(input int rmode, input bit inject, input int max_beats);
        int    cyc   = 0;
        int    beats = 0;
        bit    rdy;
        beat_t e;
        while (exp_q.size() > 0 && beats < max_beats && cyc < 300) begin
            e = exp_q[0];
            chk("valid", 32'(out_valid), 32'd1);
            chk("busy", 32'(busy), 32'd1);
            chk("done_mid", 32'(done), 32'd0);
            chk("data", 32'(out_data), 32'(e.data));
            chk("row", 32'(out_row), 32'(e.row));
            chk("col", 32'(out_col), 32'(e.col));
            chk("last", 32'(out_last), 32'(e.last));
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = pat[cyc % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (inject && cyc == 4) begin
                start = 1'b1;
                fill_random();
                scramble_inputs();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (rdy) begin
                void'(exp_q.pop_front());
                beats++;
            end
        end
        start = 1'b0;
        if (cyc >= 300) chk("drain_timeout", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_valid", 32'(out_valid), 32'd0);
            chk("done_busy", 32'(busy), 32'd1);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        col_major  = 1'b0;
        out_ready  = 1'b0;
        in_results = '1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_row", 32'(out_row), 32'd0);
        chk("rst_col", 32'(out_col), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 32'(busy), 32'd0);

        // Row-major, ready held high, inputs scrambled after the start edge.
        fill_pattern();
        start_tile(1'b0);
        drain(0, 1'b0, 100);

        // Column-major on the same data, started the cycle after done.
        start_tile(1'b1);
        drain(0, 1'b0, 100);

        // Backpressure with a fixed ready pattern, then random ready.
        fill_random();
        start_tile(1'b0);
        drain(1, 1'b0, 100);
        fill_random();
        start_tile(1'b1);
        drain(2, 1'b0, 100);

        // Signed extremes pass bit-exact.
        fill_random();
        m[0][0] = 16'h8000;
        m[2][2] = 16'hFFFF;
        start_tile(1'b0);
        drain(2, 1'b0, 100);

        // Start while busy is ignored and not queued.
        fill_pattern();
        start_tile(1'b0);
        drain(0, 1'b1, 100);
        @(negedge clk);
        chk("no_queued_start", 32'(out_valid), 32'd0);
        chk("no_queued_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a tile.
        fill_pattern();
        start_tile(1'b1);
        drain(0, 1'b0, 5);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        fill_pattern();
        start_tile(1'b0);
        drain(0, 1'b0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
